lphy_pwr_mtr_multi: RTL and testbench

// Per-layer power meter for the LPHY IFFT/FFT sample paths. It generalises the fixed two-layer (l1/l2) power-meter interrupts to NUM_LAYERS lanes.
// For each lane it computes |IQ|^2 per sample and accumulates it over a programmable window, along with peak power and an over-threshold count.
// At window end it latches the results into CSR-readable shadow registers and raises a maskable per-lane done IRQ.
// It sits on clk_dsp beside the IFFT/FFT AVST taps, behind the pwr_mtr h2f bridge.

---
 rtl/lphy_pwr_mtr_multi.sv | 146 ++++++++++++++
 tb/tb_lphy_pwr_mtr_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lphy_pwr_mtr_multi.sv
// lphy_pwr_mtr_multi: per-lane IQ power meter with windowed accumulate, peak, over-threshold count and done IRQs
module lphy_pwr_mtr_multi #(
    parameter int NUM_LAYERS = 4,
    parameter int IQ_W = 16,
    parameter int ACC_W = 48,
    parameter int WIN_W = 24
) (
    input  logic                           clk_dsp_clk,
    input  logic                           reset_dsp_reset,
    input  logic [NUM_LAYERS-1:0]          sink_valid,
    input  logic [NUM_LAYERS*2*IQ_W-1:0]   sink_data,
    input  logic [7:0]                     csr_address,
    input  logic                           csr_read,
    input  logic                           csr_write,
    input  logic [31:0]                    csr_writedata,
    output logic [31:0]                    csr_readdata,
    output logic                           csr_readdatavalid,
    output logic [NUM_LAYERS-1:0]          pwr_mtr_done_intr_irq
);
    localparam int IQ2 = 2 * IQ_W;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} st_t;
    logic                  en, cont, ctrl_wr, start, en_nx;
    logic [WIN_W-1:0]      win, win_eff;
    logic [31:0]           thresh, rmux;
    logic [NUM_LAYERS-1:0] status, mask, done, w1c;
    logic [7:0]            ofs;
    logic [31:0]           rd [NUM_LAYERS][4];

    always_comb begin
        ctrl_wr = csr_write && csr_address == 8'h00;
        start = ctrl_wr && csr_writedata[2] && csr_writedata[0];
        en_nx = ctrl_wr ? csr_writedata[0] : en;
        win_eff = win == '0 ? WIN_W'(1) : win;
        w1c = (csr_write && csr_address == 8'h03) ? csr_writedata[NUM_LAYERS-1:0] : '0;
        ofs = csr_address - 8'h10;
        rmux = csr_address == 8'h00 ? {30'b0, cont, en} :
               csr_address == 8'h01 ? 32'(win) :
               csr_address == 8'h02 ? thresh :
               csr_address == 8'h03 ? 32'(status) :
               csr_address == 8'h04 ? 32'(mask) : 32'b0;
        for (int k = 0; k < NUM_LAYERS; k++)
            if (csr_address >= 8'h10 && ofs[7:2] == 6'(k)) rmux = rd[k][ofs[1:0]];
    end

    always_ff @(posedge clk_dsp_clk) begin
        if (reset_dsp_reset) begin
            {en, cont} <= '0;
            win <= '0;
            thresh <= '0;
            status <= '0;
            mask <= '0;
            pwr_mtr_done_intr_irq <= '0;
            csr_readdata <= '0;
            csr_readdatavalid <= 1'b0;
        end else begin
            if (ctrl_wr) {cont, en} <= csr_writedata[1:0];
            if (csr_write && csr_address == 8'h01) win <= csr_writedata[WIN_W-1:0];
            if (csr_write && csr_address == 8'h02) thresh <= csr_writedata;
            if (csr_write && csr_address == 8'h04) mask <= csr_writedata[NUM_LAYERS-1:0];
            status <= (status & ~w1c) | done;
            pwr_mtr_done_intr_irq <= status & mask;
            csr_readdatavalid <= csr_read;
            csr_readdata <= csr_read ? rmux : '0;
        end
    end

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_lane
        logic                    v1, v2, run, hit, fin;
        logic signed [IQ_W-1:0]  i1, q1;
        logic signed [IQ2-1:0]   sqi, sqq;
        logic [IQ2-1:0]          pwr, peak, peak_nx, sh_peak;
        logic [ACC_W:0]          sum;
        logic [ACC_W-1:0]        acc, acc_nx, sh_acc;
        logic [ACC_W-33:0]       hold;
        logic [31:0]             over, over_nx, sh_over;
        logic [WIN_W-1:0]        cnt;
        st_t                     st, st_nx;

        always_ff @(posedge clk_dsp_clk) begin
            if (reset_dsp_reset) begin
                {v1, v2} <= '0;
                {i1, q1} <= '0;
                {sqi, sqq} <= '0;
            end else begin
                v1 <= en & sink_valid[k];
                i1 <= sink_data[k*IQ2+IQ_W +: IQ_W];
                q1 <= sink_data[k*IQ2 +: IQ_W];
                v2 <= en & v1;
                sqi <= IQ2'(i1) * IQ2'(i1);
                sqq <= IQ2'(q1) * IQ2'(q1);
            end
        end

        always_comb begin
            pwr = $unsigned(sqi) + $unsigned(sqq);
            sum = {1'b0, acc} + (ACC_W+1)'(pwr);
            acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            peak_nx = pwr > peak ? pwr : peak;
            over_nx = ({32'b0, pwr} > {IQ2'(0), thresh} && ~&over) ? over + 1'b1 : over;
            hit = run && v2 && en_nx && !start;
            fin = hit && ({1'b0, cnt} + 1'b1 >= {1'b0, win_eff});
        end

        always_ff @(posedge clk_dsp_clk) st <= reset_dsp_reset ? IDLE : st_nx;

        always_comb st_nx = !en_nx ? IDLE : start ? RUN : (fin && !cont) ? HOLD : st;

        always_comb run = st == RUN;

        always_ff @(posedge clk_dsp_clk) begin
            if (reset_dsp_reset || start || fin) begin
                acc <= '0;
                peak <= '0;
                over <= '0;
                cnt <= '0;
            end else if (hit) begin
                acc <= acc_nx;
                peak <= peak_nx;
                over <= over_nx;
                cnt <= cnt + 1'b1;
            end
        end

        always_ff @(posedge clk_dsp_clk) begin
            if (reset_dsp_reset) begin
                sh_acc <= '0;
                sh_peak <= '0;
                sh_over <= '0;
                hold <= '0;
            end else begin
                if (fin) begin
                    sh_acc <= acc_nx;
                    sh_peak <= peak_nx;
                    sh_over <= over_nx;
                end
                if (csr_read && csr_address == 8'(16 + 4*k)) hold <= sh_acc[ACC_W-1:32];
            end
        end

        assign done[k] = fin;
        assign rd[k][0] = sh_acc[31:0];
        assign rd[k][1] = 32'(hold);
        assign rd[k][2] = 32'(sh_peak);
        assign rd[k][3] = sh_over;
    end
endmodule

// File: tb/tb_lphy_pwr_mtr_multi.sv
// tb_lphy_pwr_mtr_multi: directed scoreboard bench for the per-lane power meter (ACC_W 48 and 34 instances)
module tb_lphy_pwr_mtr_multi;
    typedef struct {string t; logic [31:0] v;} exp_t;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   sink_valid;
    logic [127:0] sink_data;
    logic [7:0]   csr_address;
    logic         csr_read, csr_write;
    logic [31:0]  csr_writedata;
    logic [31:0]  rdata0, rdata1;
    logic         rv0, rv1;
    logic [3:0]   irq0, irq1;
    exp_t         q0[$], q1[$];
    exp_t         e0, e1;
    int           n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    lphy_pwr_mtr_multi u0 (
        .clk_dsp_clk(clk), .reset_dsp_reset(rst), .sink_valid(sink_valid), .sink_data(sink_data),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_readdata(rdata0), .csr_readdatavalid(rv0), .pwr_mtr_done_intr_irq(irq0)
    );

    lphy_pwr_mtr_multi #(.ACC_W(34)) u34 (
        .clk_dsp_clk(clk), .reset_dsp_reset(rst), .sink_valid(sink_valid), .sink_data(sink_data),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_readdata(rdata1), .csr_readdatavalid(rv1), .pwr_mtr_done_intr_irq(irq1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick(1);
        sink_valid = '0;
        csr_read = 1'b0;
        csr_write = 1'b0;
    endtask

    task automatic lane(input int k, input logic signed [15:0] i, input logic signed [15:0] q);
        sink_valid[k] = 1'b1;
        sink_data[k*32 +: 32] = {i, q};
    endtask

    task automatic rd_issue(input logic [7:0] a, input logic [31:0] x0, input logic [31:0] x1, input string tag);
        csr_read = 1'b1;
        csr_address = a;
        q0.push_back('{tag, x0});
        q1.push_back('{{"u34 ", tag}, x1});
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] x, input string tag);
        rd_issue(a, x, x, tag);
        step();
    endtask

    task automatic rd2(input logic [7:0] a, input logic [31:0] x0, input logic [31:0] x1, input string tag);
        rd_issue(a, x0, x1, tag);
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        csr_write = 1'b1;
        csr_address = a;
        csr_writedata = d;
        step();
    endtask

    always @(negedge clk) begin
        if (!rst && rv0) begin
            if (q0.size() == 0) chk("rv0_unexpected", {31'b0, rv0}, 32'd0);
            else begin
                e0 = q0.pop_front();
                chk(e0.t, rdata0, e0.v);
            end
        end
        if (!rst && rv1) begin
            if (q1.size() == 0) chk("rv1_unexpected", {31'b0, rv1}, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk(e1.t, rdata1, e1.v);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sink_valid = '0;
        sink_data = '0;
        csr_address = '0;
        csr_read = 1'b0;
        csr_write = 1'b0;
        csr_writedata = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_irq", 32'(irq0), 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_rvalid", 32'(rv0), 32'd0);
        rd(8'h00, 32'd0, "rst_ctrl");
        rd(8'h10, 32'd0, "rst_acc_lo");
        // one-shot window of 4 on lane0, threshold equal to the sample power
        wr(8'h04, 32'h1);
        wr(8'h02, 32'h20000);
        wr(8'h01, 32'd4);
        wr(8'h00, 32'h5);
        repeat (4) begin
            lane(0, 16'sh0100, 16'sh0100);
            step();
        end
        tick(2);
        chk("irq_lag_status", 32'(irq0), 32'd0);
        tick(1);
        chk("irq_after_status", 32'(irq0), 32'd1);
        rd(8'h10, 32'h80000, "t1_acc_lo");
        rd(8'h11, 32'h0, "t1_acc_hi");
        rd(8'h12, 32'h20000, "t1_peak");
        rd(8'h13, 32'h0, "t1_over");
        rd(8'h03, 32'h1, "t1_status");
        rd(8'h20, 32'h0, "undef_addr");
        wr(8'h03, 32'hF);
        rd(8'h03, 32'h0, "t1_w1c");
        // threshold strictly-greater boundary: powers 17, 18, 16 against 17
        wr(8'h02, 32'd17);
        wr(8'h01, 32'd3);
        wr(8'h00, 32'h5);
        lane(0, 16'sd4, 16'sd1); step();
        lane(0, 16'sd3, 16'sd3); step();
        lane(0, 16'sd4, 16'sd0); step();
        tick(4);
        rd(8'h13, 32'd1, "t3_over");
        rd(8'h12, 32'd18, "t3_peak");
        rd(8'h10, 32'd51, "t3_acc_lo");
        wr(8'h03, 32'hF);
        // W1C lands on the same edge the window completes
        wr(8'h01, 32'd2);
        wr(8'h00, 32'h5);
        lane(0, 16'sd1, 16'sd0); step();
        lane(0, 16'sd1, 16'sd0); step();
        tick(1);
        wr(8'h03, 32'h1);
        rd(8'h03, 32'h1, "t4_set_wins");
        rd(8'h10, 32'd2, "t4_acc_lo");
        wr(8'h03, 32'hF);
        rd_issue(8'h02, 32'd17, 32'd17, "rw_old");
        csr_write = 1'b1;
        csr_writedata = 32'h55;
        step();
        rd(8'h02, 32'h55, "rw_new");
        // continuous windows of 2 with independent lanes
        wr(8'h01, 32'd2);
        wr(8'h00, 32'h7);
        lane(0, 16'sd1, 16'sd0); lane(1, 16'sd2, 16'sd0); step();
        lane(0, 16'sd1, 16'sd1); lane(1, 16'sd2, 16'sd0); step();
        lane(0, 16'sd2, 16'sd0); lane(1, 16'sd2, 16'sd0); step();
        lane(0, 16'sd2, 16'sd1); lane(2, 16'sd3, 16'sd0); step();
        lane(2, 16'sd0, 16'sd3);
        rd_issue(8'h10, 32'd3, 32'd3, "t5_first_window");
        step();
        tick(4);
        rd(8'h10, 32'd9, "t5_second_window");
        rd(8'h14, 32'd8, "t5_lane1_acc");
        rd(8'h16, 32'd4, "t5_lane1_peak");
        rd(8'h18, 32'd18, "t5_lane2_acc");
        rd(8'h1C, 32'd0, "t5_lane3_acc");
        rd(8'h03, 32'h7, "t5_status");
        wr(8'h00, 32'h0);
        rd(8'h03, 32'h7, "disable_keeps_status");
        wr(8'h03, 32'hF);
        // full-scale samples: u34 saturates, u0 does not
        wr(8'h02, 32'h0);
        wr(8'h01, 32'd16);
        wr(8'h00, 32'h5);
        repeat (16) begin
            lane(0, 16'sh8000, 16'sh8000);
            step();
        end
        tick(4);
        rd2(8'h10, 32'h0, 32'hFFFFFFFF, "t2_acc_lo");
        rd2(8'h11, 32'h8, 32'h3, "t2_acc_hi");
        rd(8'h12, 32'h80000000, "t2_peak");
        rd(8'h13, 32'd16, "t2_over");
        rd(8'h03, 32'h1, "t2_status");
        // reset in the middle of a window
        wr(8'h01, 32'd4);
        wr(8'h00, 32'h5);
        lane(0, 16'sd1, 16'sd0); step();
        lane(0, 16'sd1, 16'sd0); step();
        tick(3);
        chk("pre_rst_irq", 32'(irq0), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_irq", 32'(irq0), 32'd0);
        chk("mid_rst_irq34", 32'(irq1), 32'd0);
        chk("mid_rst_rdata", rdata0, 32'd0);
        rst = 1'b0;
        lane(0, 16'sd1, 16'sd0); step();
        lane(0, 16'sd1, 16'sd0); step();
        tick(5);
        chk("post_rst_irq", 32'(irq0), 32'd0);
        rd(8'h03, 32'h0, "post_rst_status");
        rd(8'h10, 32'h0, "post_rst_acc_lo");
        rd(8'h04, 32'h0, "post_rst_mask");
        rd(8'h00, 32'h0, "post_rst_ctrl");
        tick(2);
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
